decoder_scan: RTL and testbench
===============================

// Module: decoder_scan
//
// PURPOSE
//   Parametrised, registered N-to-2^N one-hot decoder with two modes.
//   - DIRECT mode: decodes input a.
//   - SCAN mode: an internal counter steps the active output through every
//     index, dwelling DWELL cycles on each, with BLANK all-zero cycles between
//     steps.
//   Used as a row/digit scan driver for multiplexed displays and as a general
//   enable fan-out.
//
// PARAMETERS
//   N      3  select width; out is 2**N bits wide (N >= 1)
//   DWELL  4  cycles each output is high in scan mode (>= 1)
//   BLANK  1  all-zero cycles between scan steps (>= 0)
//
// PORTS
//   clk    in   1     system clock, rising edge
//   rst    in   1     asynchronous, active-high reset
//   ena    in   1     enable; 0 forces out to all-zero
//   mode   in   1     0 = DIRECT, 1 = SCAN
//   a      in   N     DIRECT select; SCAN start index
//   out    out  2**N  registered one-hot output, or all-zero
//   index  out  N     index currently (or last) driven
//   wrap   out  1     one-cycle pulse when scan index wraps 2**N-1 -> 0
//
// BEHAVIOUR
//   Clock and reset
//   - One clock: clk. Reset is asynchronous and active-high: rst.
//   - On rst: out = 0, index = 0, wrap = 0, state = IDLE, dwell counter = 0.
//   Outputs
//   - All outputs are registered. out is always one-hot or all-zero.
//   - out never has more than one bit high in any cycle.
//   States: IDLE, DIRECT, SHOW, BLANK. Each rule gives the next-state
//   registered values.
//   - Any state, ena=0 -> IDLE; out <= 0, wrap <= 0, index held.
//   - ena=1, mode=0 -> DIRECT; out <= 1<<a, index <= a, wrap <= 0.
//     Latency is 1 cycle; a is re-decoded every cycle.
//   - ena=1, mode=1, state IDLE or DIRECT -> SHOW; index <= a,
//     out <= 1<<a, cnt <= 0. The scan restarts from a.
//   - SHOW, cnt < DWELL-1 -> cnt++, out held.
//   - SHOW, cnt == DWELL-1:
//     - BLANK > 0: -> BLANK; out <= 0, cnt <= 0.
//     - BLANK == 0: stay in SHOW; index <= index+1 (mod 2**N),
//       out <= 1<<(index+1), cnt <= 0.
//   - BLANK, cnt < BLANK-1 -> cnt++.
//   - BLANK, cnt == BLANK-1 -> SHOW; index <= index+1 (mod 2**N),
//     out <= one-hot of the new index, cnt <= 0.
//   - wrap <= 1 in exactly the cycle index is loaded 2**N-1 -> 0 by a scan
//     step. Otherwise wrap <= 0, including when a start index of 0 is loaded.
//   Scan timing
//   - Each output is high exactly DWELL consecutive cycles.
//   - Scan period is (DWELL+BLANK) * 2**N cycles.
//   Boundary conditions
//   - mode 1->0 mid-scan: the next cycle is a DIRECT decode.
//   - mode 0->1 restarts the scan at a.
//   - Changes to a during SCAN are ignored.
//   - ena dropped mid-scan then restored: the scan restarts from a; there is
//     no resume.
//   - rst asserted mid-operation clears all state immediately (asynchronous).
//     The first active edge after release evaluates normally.
//   - Counter width is $clog2(max(DWELL,BLANK,2)). No overflow is possible.
//
// TESTING
//   1 rst pulse at any time -> out=0, index=0, wrap=0 with no clock edge.
//   2 N=3, ena=1, mode=0, a=5 -> out=8'h20, index=5 one cycle later;
//     a=0 -> 8'h01 next cycle; ena=0 -> 8'h00 next cycle.
//   3 N=3, DWELL=2, BLANK=1, mode=1, a=6 -> out per cycle:
//     40,40,00,80,80,00,01,01 ...; wrap=1 only on the first 01 cycle.
//   4 N=2, DWELL=1, BLANK=0, scan from a=0 -> 1,2,4,8,1 ... every cycle;
//     wrap pulses every 4 cycles.
//   5 Mid-scan (SHOW, index=3): mode->0 with a=1 -> out=02 next cycle.
//     Then mode->1 -> scan restarts at index 1.
//   6 Async rst mid-BLANK -> out=0 at once. After release with ena=1,
//     mode=1, a=2: out=04 after one edge.
//   Checker: every cycle, $onehot0(out), and out == (1<<index) whenever in
//   SHOW or DIRECT.

Source files
------------

// File: rtl/decoder_scan.sv
// Registered N-to-2^N one-hot decoder with a direct mode and a self-stepping
// scan mode (dwell / blank timing) for multiplexed display drive.
module decoder_scan #(
   parameter int N     = 3,
   parameter int DWELL = 4,
   parameter int BLANK = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic              mode,
   input  logic [N-1:0]      a,
   output logic [2**N-1:0]   out,
   output logic [N-1:0]      index,
   output logic              wrap
);

   localparam int W      = 2**N;
   localparam int CMAX_DB = (DWELL > BLANK) ? DWELL : BLANK;
   localparam int CMAX   = (CMAX_DB > 2) ? CMAX_DB : 2;
   localparam int CW     = $clog2(CMAX);
   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
   // Never compared against when BLANK is zero, since the blank state is unreachable.
   localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? (BLANK - 1) : 0);
   localparam logic [N-1:0]  INDEX_MAX  = {N{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DIRECT,
      ST_SHOW,
      ST_BLANK
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]    out_q, out_d;
   logic [N-1:0]    index_q, index_d;
   logic            wrap_q, wrap_d;

   logic [N-1:0]    index_step;
   logic [W-1:0]    dec_a;
   logic [W-1:0]    dec_step;

   assign index_step = index_q + 1'b1;

   // Equality decoders for the input select and the next scan index.
   generate
      for (genvar gi = 0; gi < W; gi++) begin : g_dec
         assign dec_a[gi]    = (a == N'(gi));
         assign dec_step[gi] = (index_step == N'(gi));
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      index_d = index_q;
      wrap_d  = 1'b0;

      if (!ena) begin
         state_d = ST_IDLE;
         out_d   = '0;
         cnt_d   = '0;
      end else if (!mode) begin
         state_d = ST_DIRECT;
         out_d   = dec_a;
         index_d = a;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DIRECT: begin
               state_d = ST_SHOW;
               out_d   = dec_a;
               index_d = a;
               cnt_d   = '0;
            end
            ST_SHOW: begin
               if (cnt_q == DWELL_LAST) begin
                  cnt_d = '0;
                  if (BLANK > 0) begin
                     state_d = ST_BLANK;
                     out_d   = '0;
                  end else begin
                     out_d   = dec_step;
                     index_d = index_step;
                     wrap_d  = (index_q == INDEX_MAX);
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_BLANK: begin
               if (cnt_q == BLANK_LAST) begin
                  state_d = ST_SHOW;
                  cnt_d   = '0;
                  out_d   = dec_step;
                  index_d = index_step;
                  wrap_d  = (index_q == INDEX_MAX);
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               out_d   = '0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         out_q   <= '0;
         index_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         index_q <= index_d;
         wrap_q  <= wrap_d;
      end
   end

   assign out   = out_q;
   assign index = index_q;
   assign wrap  = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Scoreboard bench for decoder_scan: directed steps queue expected values,
// a monitor pops and compares one entry per clock.
module tb_decoder_scan;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic       ena_a = 1'b0, mode_a = 1'b0;
   logic [2:0] a_a = '0;
   logic [7:0] out_a;
   logic [2:0] idx_a;
   logic       wrap_a;

   logic       ena_b = 1'b0, mode_b = 1'b0;
   logic [1:0] a_b = '0;
   logic [3:0] out_b;
   logic [1:0] idx_b;
   logic       wrap_b;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         id;
      logic [7:0] eout;
      logic [2:0] eidx;
      logic       ewrap;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   decoder_scan #(.N(3), .DWELL(2), .BLANK(1)) dut_a (
      .clk(clk), .rst(rst), .ena(ena_a), .mode(mode_a), .a(a_a),
      .out(out_a), .index(idx_a), .wrap(wrap_a)
   );

   decoder_scan #(.N(2), .DWELL(1), .BLANK(0)) dut_b (
      .clk(clk), .rst(rst), .ena(ena_b), .mode(mode_b), .a(a_b),
      .out(out_b), .index(idx_b), .wrap(wrap_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic step(input int id, input logic en, input logic md, input logic [2:0] av,
                       input logic [7:0] eo, input logic [2:0] ei, input logic ew);
      exp_t e;
      @(negedge clk);
      if (id == 0) begin
         ena_a = en; mode_a = md; a_a = av;
      end else begin
         ena_b = en; mode_b = md; a_b = av[1:0];
      end
      e.id = id; e.eout = eo; e.eidx = ei; e.ewrap = ew;
      exp_q.push_back(e);
   endtask

   // Monitor: invariant on dut_a every cycle, plus one scoreboard entry per edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (!rst) begin
         chk("onehot0_a", {31'd0, $onehot0(out_a)}, 32'd1);
         if (out_a != 8'h00)
            chk("out_matches_index_a", {24'd0, out_a}, {24'd0, 8'd1 << idx_a});
      end
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (e.id == 0) begin
            $display("t=%0t dut_a out=%02h index=%0d wrap=%0b", $time, out_a, idx_a, wrap_a);
            chk("out_a", {24'd0, out_a}, {24'd0, e.eout});
            chk("index_a", {29'd0, idx_a}, {29'd0, e.eidx});
            chk("wrap_a", {31'd0, wrap_a}, {31'd0, e.ewrap});
         end else begin
            $display("t=%0t dut_b out=%01h index=%0d wrap=%0b", $time, out_b, idx_b, wrap_b);
            chk("out_b", {28'd0, out_b}, {24'd0, e.eout});
            chk("index_b", {30'd0, idx_b}, {29'd0, e.eidx});
            chk("wrap_b", {31'd0, wrap_b}, {31'd0, e.ewrap});
         end
      end
   end

   initial begin
      exp_t e;
      #2;
      chk("reset_out_a", {24'd0, out_a}, 32'd0);
      chk("reset_index_a", {29'd0, idx_a}, 32'd0);
      chk("reset_out_b", {28'd0, out_b}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Direct decode and disable.
      step(0, 1, 0, 3'd5, 8'h20, 3'd5, 0);
      step(0, 1, 0, 3'd0, 8'h01, 3'd0, 0);
      step(0, 0, 0, 3'd0, 8'h00, 3'd0, 0);
      // Scan from 6 with DWELL=2, BLANK=1; a changes are ignored.
      step(0, 1, 1, 3'd6, 8'h40, 3'd6, 0);
      step(0, 1, 1, 3'd3, 8'h40, 3'd6, 0);
      step(0, 1, 1, 3'd3, 8'h00, 3'd6, 0);
      step(0, 1, 1, 3'd3, 8'h80, 3'd7, 0);
      step(0, 1, 1, 3'd3, 8'h80, 3'd7, 0);
      step(0, 1, 1, 3'd3, 8'h00, 3'd7, 0);
      step(0, 1, 1, 3'd3, 8'h01, 3'd0, 1);
      step(0, 1, 1, 3'd3, 8'h01, 3'd0, 0);
      step(0, 1, 1, 3'd3, 8'h00, 3'd0, 0);
      step(0, 1, 1, 3'd3, 8'h02, 3'd1, 0);
      step(0, 1, 1, 3'd3, 8'h02, 3'd1, 0);
      step(0, 1, 1, 3'd3, 8'h00, 3'd1, 0);
      step(0, 1, 1, 3'd3, 8'h04, 3'd2, 0);
      step(0, 1, 1, 3'd3, 8'h04, 3'd2, 0);
      step(0, 1, 1, 3'd3, 8'h00, 3'd2, 0);
      step(0, 1, 1, 3'd3, 8'h08, 3'd3, 0);
      // Mid-scan switch to direct, then back to scan from a.
      step(0, 1, 0, 3'd1, 8'h02, 3'd1, 0);
      step(0, 1, 1, 3'd1, 8'h02, 3'd1, 0);
      step(0, 1, 1, 3'd1, 8'h02, 3'd1, 0);
      step(0, 1, 1, 3'd1, 8'h00, 3'd1, 0);

      // Asynchronous reset while in BLANK, released before the next edge.
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("async_rst_out_a", {24'd0, out_a}, 32'd0);
      chk("async_rst_index_a", {29'd0, idx_a}, 32'd0);
      chk("async_rst_wrap_a", {31'd0, wrap_a}, 32'd0);
      ena_a = 1'b1; mode_a = 1'b1; a_a = 3'd2;
      e.id = 0; e.eout = 8'h04; e.eidx = 3'd2; e.ewrap = 1'b0;
      exp_q.push_back(e);
      #1 rst = 1'b0;

      step(0, 1, 1, 3'd2, 8'h04, 3'd2, 0);
      step(0, 1, 1, 3'd2, 8'h00, 3'd2, 0);
      // ena drop holds index; restore restarts from a.
      step(0, 0, 1, 3'd2, 8'h00, 3'd2, 0);
      step(0, 1, 1, 3'd5, 8'h20, 3'd5, 0);
      // Loading start index 0 must not raise wrap.
      step(0, 1, 0, 3'd0, 8'h01, 3'd0, 0);
      step(0, 1, 1, 3'd0, 8'h01, 3'd0, 0);
      step(0, 0, 0, 3'd0, 8'h00, 3'd0, 0);

      // N=2, DWELL=1, BLANK=0: steps every cycle, wrap every 4.
      step(1, 1, 1, 3'd0, 8'h01, 3'd0, 0);
      step(1, 1, 1, 3'd0, 8'h02, 3'd1, 0);
      step(1, 1, 1, 3'd0, 8'h04, 3'd2, 0);
      step(1, 1, 1, 3'd0, 8'h08, 3'd3, 0);
      step(1, 1, 1, 3'd0, 8'h01, 3'd0, 1);
      step(1, 1, 1, 3'd0, 8'h02, 3'd1, 0);
      step(1, 1, 1, 3'd0, 8'h04, 3'd2, 0);
      step(1, 1, 1, 3'd0, 8'h08, 3'd3, 0);
      step(1, 1, 1, 3'd0, 8'h01, 3'd0, 1);
      step(1, 0, 0, 3'd0, 8'h00, 3'd0, 0);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
